e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit. It consumes the operand outputs of the E-stage pipeline register (rs/rt data and the decoded operation) and holds the architectural HI/LO registers. Multi-cycle operations raise a stall request back to the hazard logic, which in turn drops the pipeline-register enables. It is the downstream consumer and back-pressure source for the E-stage register.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  operation valid this cycle (E-stage instruction is an MDU op)
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- rs_data  input  32  operand A / mthi-mtlo source
- rt_data  input  32  operand B
- busy  output  1  multi-cycle operation in progress
- stall_req  output  1  combinational: busy | (start & op∈{1..4})
- hi  output  32  architectural HI (registered)
- lo  output  32  architectural LO (registered)

## Operation
- States: IDLE, RUN. Down-counter cnt, width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)))+1.
- IDLE, start & op∈{1..4}: capture rs_data/rt_data, compute the result into pending registers p_hi/p_lo, load cnt with MULT_CYCLES or DIV_CYCLES, go to RUN.
- RUN: decrement cnt each cycle. When cnt reaches 1, on that edge: hi<=p_hi, lo<=p_lo, go to IDLE.
- mult: signed 32x32→64; hi=[63:32], lo=[31:0]. multu: unsigned, same split.
- div: lo=signed quotient truncated toward zero; hi=remainder with the sign of the dividend. divu: unsigned quotient/remainder.
- Divide by zero (rt_data==0, div or divu): still runs DIV_CYCLES; at completion hi/lo keep their prior values.
- div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo in IDLE with start: hi<=rs_data or lo<=rs_data on the same edge; single cycle; busy stays 0.
- start while busy (any op): ignored. The hazard unit guarantees the instruction is held by stall_req; the re-presented op is accepted once busy falls.
- op 0/7 with start: no effect.
- Reset (any time, including mid-RUN): state IDLE, cnt=0, busy=0, hi=0, lo=0, p_hi=p_lo=0; the in-flight result is discarded.

## Timing
- Reset values: busy=0, hi=0, lo=0; stall_req = start & op∈{1..4}.
- Accept edge E0 (start sampled in IDLE). busy=1 from after E0 through the cycle before the commit edge. N=MULT_CYCLES or DIV_CYCLES.
- Commit edge E_N: hi/lo update and busy->0 on the same edge. New values are visible from cycle N+1 after acceptance, so mfhi/mflo in that cycle reads them.
- Throughput: a new multi-cycle op can be accepted on edge E_N+1 (the first IDLE cycle); back-to-back ops cost N+1 cycles each.
- stall_req is high in the accept cycle and every busy cycle, and low in the first cycle after commit.
- hi/lo outputs are stable during RUN (old values) until the commit edge.

## Test plan
- mult rs=0xFFFFFFFD (-3), rt=5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall_req high in the accept cycle and all busy cycles.
- multu rs=0xFFFFFFFF, rt=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; then div rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu rs=7, rt=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- During a div, hold start with op=mtlo, rs=0xABCD -> ignored while busy; lo takes the div result at commit; mtlo is accepted in the first IDLE cycle and lo=0xABCD on the next edge.
- Assert reset asynchronously (between edges) in cycle 3 of a mult -> busy, hi, lo go to 0 immediately without a clock edge; no commit occurs afterward.
- Parameter sweep MULT_CYCLES=1, DIV_CYCLES=1 -> busy high for exactly one cycle; results committed on the next edge; stall_req pattern matches.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Multi-cycle ops compute at accept and commit after a fixed latency.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [31:0]    p_hi, p_lo;
  logic           is_md, is_mult, accept, commit;

  logic [63:0]    s_prod, u_prod;
  logic [31:0]    num, den, den_safe, uq, ur;
  logic [31:0]    res_hi, res_lo;

  assign is_md   = (op >= OP_MULT) && (op <= OP_DIVU);
  assign is_mult = (op == OP_MULT) || (op == OP_MULTU);
  assign accept  = (state == IDLE) && start && is_md;
  assign commit  = (state == RUN) && (cnt == CW'(1));

  assign busy      = (state == RUN);
  assign stall_req = busy | (start & is_md);

  assign s_prod = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign u_prod = {32'b0, rs_data} * {32'b0, rt_data};

  // One unsigned divider serves both forms; signed div works on magnitudes and
  // restores signs afterwards, which also yields 0x80000000/-1 = 0x80000000 r 0.
  always_comb begin
    num = rs_data;
    den = rt_data;
    if (op == OP_DIV) begin
      num = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
      den = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
    end
  end

  assign den_safe = (den == 32'd0) ? 32'd1 : den;
  assign uq = num / den_safe;
  assign ur = num % den_safe;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (op)
      OP_MULT:  {res_hi, res_lo} = s_prod;
      OP_MULTU: {res_hi, res_lo} = u_prod;
      OP_DIV: begin
        if (rt_data != 32'd0) begin
          res_lo = (rs_data[31] ^ rt_data[31]) ? (~uq + 32'd1) : uq;
          res_hi = rs_data[31] ? (~ur + 32'd1) : ur;
        end
      end
      OP_DIVU: begin
        if (rt_data != 32'd0) begin
          res_lo = uq;
          res_hi = ur;
        end
      end
      default: begin
        res_hi = hi;
        res_lo = lo;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (commit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divide-by-zero captures the current HI/LO as pending, so commit is a no-op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      p_hi <= '0;
      p_lo <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (accept) begin
        p_hi <= res_hi;
        p_lo <= res_lo;
        cnt  <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
        if (commit) begin
          hi <= p_hi;
          lo <= p_lo;
        end
      end else if (start && op == OP_MTHI) begin
        hi <= rs_data;
      end else if (start && op == OP_MTLO) begin
        lo <= rs_data;
      end
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: default latencies plus a single-cycle instance,
// selected through a shared stimulus path.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        sel = 1'b0;

  logic        busy0, stall0, busy1, stall1;
  logic [31:0] hi0, lo0, hi1, lo1;
  logic        start0, start1;
  logic        obs_busy, obs_stall;
  logic [31:0] obs_hi, obs_lo;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] cur_hi, cur_lo;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign obs_busy  = sel ? busy1  : busy0;
  assign obs_stall = sel ? stall1 : stall0;
  assign obs_hi    = sel ? hi1    : hi0;
  assign obs_lo    = sel ? lo1    : lo0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start0), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy0), .stall_req(stall0), .hi(hi0), .lo(lo0)
  );

  e_mdu #(.MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy1), .stall_req(stall1), .hi(hi1), .lo(lo1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge; accepts on the next posedge and checks every busy cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] new_hi, input logic [31:0] new_lo);
    int busy_cnt;
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    #1;
    check({tag, "_acc_stall"}, {31'b0, obs_stall}, 32'd1);
    check({tag, "_acc_busy"}, {31'b0, obs_busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (obs_busy === 1'b1) busy_cnt++;
      check({tag, "_run_stall"}, {31'b0, obs_stall}, 32'd1);
      check({tag, "_run_hi"}, obs_hi, cur_hi);
      check({tag, "_run_lo"}, obs_lo, cur_lo);
    end
    check({tag, "_busy_cycles"}, busy_cnt, n);
    @(negedge clk);
    check({tag, "_done_busy"}, {31'b0, obs_busy}, 32'd0);
    check({tag, "_done_stall"}, {31'b0, obs_stall}, 32'd0);
    check({tag, "_hi"}, obs_hi, new_hi);
    check({tag, "_lo"}, obs_lo, new_lo);
    cur_hi = new_hi;
    cur_lo = new_lo;
  endtask

  // Called at a negedge; single-cycle op (mthi/mtlo/none).
  task automatic single_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] new_hi, input logic [31:0] new_lo);
    start = 1'b1; op = o; rs_data = a;
    #1;
    check({tag, "_stall"}, {31'b0, obs_stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    @(negedge clk);
    check({tag, "_busy"}, {31'b0, obs_busy}, 32'd0);
    check({tag, "_hi"}, obs_hi, new_hi);
    check({tag, "_lo"}, obs_lo, new_lo);
    cur_hi = new_hi;
    cur_lo = new_lo;
  endtask

  initial begin
    cur_hi = '0;
    cur_lo = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, obs_busy}, 32'd0);
    check("rst_stall", {31'b0, obs_stall}, 32'd0);
    check("rst_hi", obs_hi, 32'd0);
    check("rst_lo", obs_lo, 32'd0);

    run_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    single_op("mthi", 3'd5, 32'h11, 32'h11, cur_lo);
    single_op("mtlo", 3'd6, 32'h22, 32'h11, 32'h22);
    run_op("divu_zero", 3'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    single_op("op7", 3'd7, 32'h5555, 32'h0, 32'h8000_0000);
    single_op("op0", 3'd0, 32'h5555, 32'h0, 32'h8000_0000);

    // mtlo held during a div: ignored until busy falls, then accepted.
    start = 1'b1; op = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1;
    op = 3'd6; rs_data = 32'hABCD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_busy", {31'b0, obs_busy}, 32'd1);
      check("hold_lo", obs_lo, 32'h8000_0000);
    end
    @(negedge clk);
    check("hold_done_stall", {31'b0, obs_stall}, 32'd0);
    check("hold_div_lo", obs_lo, 32'hE);
    check("hold_div_hi", obs_hi, 32'h2);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    @(negedge clk);
    check("hold_mtlo", obs_lo, 32'hABCD);
    check("hold_mtlo_hi", obs_hi, 32'h2);
    cur_hi = 32'h2;
    cur_lo = 32'hABCD;

    // Single-cycle latency instance.
    sel = 1'b1;
    cur_hi = '0;
    cur_lo = '0;
    #1;
    check("sw_rst_hi", obs_hi, 32'd0);
    run_op("sw_mult", 3'd1, 32'd6, 32'd7, 1, 32'd0, 32'd42);
    run_op("sw_divu", 3'd4, 32'd100, 32'd7, 1, 32'd2, 32'd14);
    run_op("sw_div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    sel = 1'b0;
    #1;

    // Asynchronous reset in the third busy cycle of a mult.
    start = 1'b1; op = 3'd1; rs_data = 32'd6; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy0}, 32'd0);
    check("arst_hi", hi0, 32'd0);
    check("arst_lo", lo0, 32'd0);
    check("arst_hi1", hi1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("arst_after_busy", {31'b0, busy0}, 32'd0);
    check("arst_after_hi", hi0, 32'd0);
    check("arst_after_lo", lo0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
